// File: rtl/axil_arb_pkg.sv
// Shared types and widths for the two-port AXI-lite read arbiter.
package axil_arb_pkg;

  typedef enum logic {PORT_IF = 1'b0, PORT_DM = 1'b1} port_id_t;

  localparam int NUM_RD_PORTS = 2;
  localparam int ADDR_W       = 32;
  localparam int DATA_W       = 32;

  function automatic port_id_t other_port(input port_id_t p);
    return (p == PORT_IF) ? PORT_DM : PORT_IF;
  endfunction

endpackage

// File: rtl/axil_interface_if.sv
// AXI-lite read channel (AR + R) bundle; rd_mst issues reads, rd_slv serves them.
interface axil_interface_if;

  logic [axil_arb_pkg::ADDR_W-1:0] araddr;
  logic                            arvalid;
  logic                            arready;
  logic [axil_arb_pkg::DATA_W-1:0] rdata;
  logic [1:0]                      rresp;
  logic                            rvalid;
  logic                            rready;

  modport rd_mst (
    output araddr, arvalid, rready,
    input  arready, rdata, rresp, rvalid
  );

  modport rd_slv (
    input  araddr, arvalid, rready,
    output arready, rdata, rresp, rvalid
  );

endinterface

// File: rtl/arb_id_fifo.sv
// Small synchronous FIFO recording which port issued each accepted read, in issue order.
module arb_id_fifo
  import axil_arb_pkg::*;
#(
  parameter int  DEPTH = 4,
  parameter type T     = port_id_t
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         push,
  input  T                             push_data,
  input  logic                         pop,
  output T                             head,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH+1);

  T                 store [DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [CNT_W-1:0] count_reg;

  // Pointers wrap explicitly so non-power-of-two depths work.
  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH-1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk) begin
    if (push) begin
      store[wr_ptr_reg] <= push_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) wr_ptr_reg <= next_ptr(wr_ptr_reg);
      if (pop)  rd_ptr_reg <= next_ptr(rd_ptr_reg);
      case ({push, pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

  assign head  = store[rd_ptr_reg];
  assign full  = (count_reg == CNT_W'(DEPTH));
  assign empty = (count_reg == '0);
  assign count = count_reg;

endmodule

// File: rtl/axil_read_arbiter.sv
// Two-port AXI-lite read arbiter: round-robin (or fixed) AR grant with zero added latency,
// in-order R steering driven by a FIFO of issuing-port IDs.
module axil_read_arbiter
  import axil_arb_pkg::*;
#(
  parameter int MAX_OUTSTANDING = 4,
  parameter bit FIXED_PRIO      = 1'b0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  axil_interface_if.rd_slv         if_rd,
  axil_interface_if.rd_slv         dm_rd,
  axil_interface_if.rd_mst         mem_rd,
  output logic                     busy
);

  localparam int CNT_W = $clog2(MAX_OUTSTANDING+1);

  logic [NUM_RD_PORTS-1:0] req_vec;
  port_id_t                grant;
  logic                    grant_valid;
  logic                    sel_arvalid;
  logic                    lock_reg;
  port_id_t                lock_port_reg;
  port_id_t                last_grant_reg;
  logic                    busy_reg;
  logic                    fifo_full;
  logic                    fifo_empty;
  port_id_t                head;
  logic [CNT_W-1:0]        count;
  logic [CNT_W-1:0]        count_next;
  logic                    ar_hs;
  logic                    r_hs;

  assign req_vec = {dm_rd.arvalid, if_rd.arvalid};

  always_comb begin
    grant       = PORT_IF;
    grant_valid = 1'b0;
    if (lock_reg) begin
      grant       = lock_port_reg;
      grant_valid = 1'b1;
    end else if (!fifo_full && (req_vec != '0)) begin
      grant_valid = 1'b1;
      if (req_vec == 2'b11) begin
        grant = FIXED_PRIO ? PORT_DM : other_port(last_grant_reg);
      end else begin
        grant = req_vec[1] ? PORT_DM : PORT_IF;
      end
    end
  end

  // Requesters keep driving arvalid during reset; gate so nothing leaks downstream.
  assign sel_arvalid    = (grant == PORT_DM) ? dm_rd.arvalid : if_rd.arvalid;
  assign mem_rd.arvalid = rst_n && grant_valid && sel_arvalid;
  assign mem_rd.araddr  = (grant == PORT_DM) ? dm_rd.araddr : if_rd.araddr;
  assign if_rd.arready  = rst_n && grant_valid && (grant == PORT_IF) && mem_rd.arready;
  assign dm_rd.arready  = rst_n && grant_valid && (grant == PORT_DM) && mem_rd.arready;

  assign if_rd.rvalid   = !fifo_empty && (head == PORT_IF) && mem_rd.rvalid;
  assign dm_rd.rvalid   = !fifo_empty && (head == PORT_DM) && mem_rd.rvalid;
  assign if_rd.rdata    = mem_rd.rdata;
  assign dm_rd.rdata    = mem_rd.rdata;
  assign if_rd.rresp    = mem_rd.rresp;
  assign dm_rd.rresp    = mem_rd.rresp;
  assign mem_rd.rready  = !fifo_empty && ((head == PORT_DM) ? dm_rd.rready : if_rd.rready);

  assign ar_hs      = mem_rd.arvalid && mem_rd.arready;
  assign r_hs       = mem_rd.rvalid && mem_rd.rready;
  assign count_next = count + CNT_W'(ar_hs) - CNT_W'(r_hs);

  arb_id_fifo #(
    .DEPTH (MAX_OUTSTANDING),
    .T     (port_id_t)
  ) u_id_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (ar_hs),
    .push_data (grant),
    .pop       (r_hs),
    .head      (head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (count)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lock_reg       <= 1'b0;
      lock_port_reg  <= PORT_IF;
      last_grant_reg <= PORT_DM;
      busy_reg       <= 1'b0;
    end else begin
      lock_reg      <= mem_rd.arvalid && !mem_rd.arready;
      lock_port_reg <= grant;
      if (ar_hs) begin
        last_grant_reg <= grant;
      end
      busy_reg <= (count_next != '0);
    end
  end

  assign busy = busy_reg;

  a_no_pop_empty: assert property (@(posedge clk) disable iff (!rst_n) r_hs |-> !fifo_empty);
  a_no_push_full: assert property (@(posedge clk) disable iff (!rst_n) ar_hs |-> !fifo_full);
  a_addr_stable:  assert property (@(posedge clk) disable iff (!rst_n) lock_reg |-> $stable(mem_rd.araddr));
  a_no_stray_r:   assert property (@(posedge clk) disable iff (!rst_n) mem_rd.rvalid |-> !fifo_empty);

endmodule
